// File: rtl/fft_job_scheduler_if.sv
// ---------------------------------------------------------------------------
// fft_job_scheduler_if
//   Bundles the requester and fft_core handshake signals of fft_job_scheduler.
//   slave  : scheduler side (consumes req/fft_done, drives grant..rsp_err)
//   master : requester/core side (drives req/fft_done, observes the rest)
//   Signals:
//     req       requester -> sched  NUM_REQ  level request per requester
//     grant     sched -> requester  NUM_REQ  one-hot owner of the core
//     job_id    sched -> core       ID_W     binary owner index (bank mux select)
//     busy      sched -> any        1        scheduler not idle
//     start_fft sched -> core       1        one-cycle start pulse
//     fft_done  core  -> sched      1        completion pulse
//     rsp_valid sched -> requester  NUM_REQ  one-hot completion pulse
//     rsp_err   sched -> requester  1        job aborted by watchdog
// ---------------------------------------------------------------------------
interface fft_job_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    job_id;
    logic               busy;
    logic               start_fft;
    logic               fft_done;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               rsp_err;

    modport slave (
        input  req, fft_done,
        output grant, job_id, busy, start_fft, rsp_valid, rsp_err
    );

    modport master (
        output req, fft_done,
        input  grant, job_id, busy, start_fft, rsp_valid, rsp_err
    );
endinterface

// File: rtl/fft_job_scheduler.sv
// ---------------------------------------------------------------------------
// fft_job_scheduler
//   Shares one fft_core between NUM_REQ requesters. Pending requests are
//   arbitrated round-robin; the winner is granted the core, a start_fft pulse
//   is issued, the scheduler waits for fft_done and then returns a one-hot
//   completion pulse to the owner.
//
//   Ports:
//     clk    in  single clock, rising edge
//     reset  in  asynchronous, active-high
//     bus    fft_job_scheduler_if.slave (req, grant, job_id, busy, start_fft,
//            fft_done, rsp_valid, rsp_err)
//
//   Parameters:
//     NUM_REQ       requesters (2..8); must match the interface instance
//     DONE_TIMEOUT  WAIT cycles before the watchdog aborts a job
//
//   Optional feature macro: FFT_WDOG_EN
//     defined   : watchdog counts WAIT cycles; at DONE_TIMEOUT without
//                 fft_done the job completes with rsp_err=1.
//     undefined : WAIT holds until fft_done; rsp_err is constant 0.
//
//   FSM: IDLE -> START -> WAIT -> RESP -> IDLE. All outputs are registered.
// ---------------------------------------------------------------------------
module fft_job_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DONE_TIMEOUT = 64
) (
    input logic                clk,
    input logic                reset,
    fft_job_scheduler_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity check.
    if (NUM_REQ < 2 || NUM_REQ > 8 || DONE_TIMEOUT < 1) begin : g_param_chk
        $error("fft_job_scheduler: NUM_REQ must be 2..8, DONE_TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [ID_W-1:0]    job_id_q;
    logic [ID_W-1:0]    rr_q;        // index of the last requester served
    logic               busy_q;
    logic               start_q;

`ifdef FFT_WDOG_EN
    localparam int WD_W = $clog2(DONE_TIMEOUT + 1);
    logic [WD_W-1:0]    wd_cnt_q;
    logic               rsp_err_q;
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first set req bit starting just after rr_q, wrapping.
    // Starting after the last owner guarantees every pending requester is
    // served within NUM_REQ jobs.
    logic            pick_found;
    logic [ID_W-1:0] pick_id;

    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            job_id_q    <= '0;
            rr_q        <= ID_W'(NUM_REQ - 1);   // req[0] wins first
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
`ifdef FFT_WDOG_EN
            wd_cnt_q    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        job_id_q <= pick_id;
                        grant_q  <= onehot(pick_id);
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                // fft_done here is ignored: the core cannot legally finish
                // the job it is only now being told to start.
                S_START: begin
                    start_q <= 1'b0;
`ifdef FFT_WDOG_EN
                    wd_cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.fft_done) begin
                        rsp_valid_q <= onehot(job_id_q);
                        state_q     <= S_RESP;
                    end
`ifdef FFT_WDOG_EN
                    // A real fft_done in the final watchdog cycle takes
                    // priority (branch above), so rsp_err stays low.
                    else if (wd_cnt_q == WD_W'(DONE_TIMEOUT - 1)) begin
                        rsp_valid_q <= onehot(job_id_q);
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    grant_q     <= '0;
                    busy_q      <= 1'b0;
                    rr_q        <= job_id_q;
`ifdef FFT_WDOG_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.job_id    = job_id_q;
    assign bus.busy      = busy_q;
    assign bus.start_fft = start_q;
    assign bus.rsp_valid = rsp_valid_q;
`ifdef FFT_WDOG_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule
